// File: rtl/debouncing.sv
// -----------------------------------------------------------------------------
// debouncing
//
// Conditions the raw keypad row lines for the elevator controller. Each row
// bit is synchronised to clk and filtered for contact bounce. Every accepted
// press (0->1 change of the filtered state) becomes a single-cycle pulse on
// buttonMux, gated combinationally by en.
//
// Parameters
//   WIDTH            number of row lines
//   SYNC_STAGES      synchroniser flops per line (must be >= 2)
//   DEBOUNCE_CYCLES  consecutive clock edges the synchronised input must
//                    disagree with the filtered state before it is accepted
//                    (must be >= 1; 1 makes the filter a plain register)
//
// Ports
//   clk        in   1      system clock, all logic on posedge
//   rst        in   1      asynchronous reset, active-low (0 = reset)
//   en         in   1      output enable, active-high
//   row        in   WIDTH  raw asynchronous row inputs (1 = pressed)
//   buttonMux  out  WIDTH  one-cycle press pulse per row bit
//
// Build option
//   DEBOUNCING_ONEHOT_EN  when defined, if several bits would pulse in the
//                         same cycle only the lowest-index one is kept, so
//                         buttonMux is always one-hot or zero. When undefined
//                         every rising bit is reported at once.
//
// Latency with default parameters: a row rise seen at posedge k shows on
// buttonMux after posedge k+2 and lasts exactly one cycle. en does not stall
// the filter; a pulse that falls in a cycle with en = 0 is lost.
// -----------------------------------------------------------------------------
module debouncing #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] row,
    output logic [WIDTH-1:0] buttonMux
);

    // Counter only has to reach DEBOUNCE_CYCLES-1; the extra headroom from
    // $clog2(N+1) keeps the width at least one bit for N = 1.
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] pulse_q;
    logic [WIDTH-1:0] pulse_d;
    logic [WIDTH-1:0] rise;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] sync_q;
            logic [CNT_W-1:0]       cnt_q;
            logic [CNT_W-1:0]       cnt_d;
            logic                   s;
            logic                   stable_bit_d;

            // Synchroniser chain; bit 0 is the first flop after the pin.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], row[gi]};
                end
            end

            assign s = sync_q[SYNC_STAGES-1];

            // cnt_q holds how many previous consecutive edges s has disagreed
            // with the filtered state. The edge that would make the run
            // DEBOUNCE_CYCLES long accepts the new value instead of counting,
            // so the counter never exceeds CNT_MAX and never wraps.
            always_comb begin
                cnt_d        = '0;
                stable_bit_d = stable_q[gi];
                if (s != stable_q[gi]) begin
                    if (cnt_q >= CNT_MAX) begin
                        stable_bit_d = s;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi] = stable_bit_d;
        end
    endgenerate

    // Only presses pulse; releases (1->0) are ignored.
    assign rise = stable_d & ~stable_q;

    always_comb begin
`ifdef DEBOUNCING_ONEHOT_EN
        // x & -x isolates the lowest set bit.
        pulse_d = rise & (~rise + WIDTH'(1));
`else
        pulse_d = rise;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= '0;
            pulse_q  <= '0;
        end else begin
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
        end
    end

    // Combinational gate: dropping en suppresses the output in the same cycle.
    assign buttonMux = pulse_q & {WIDTH{en}};

endmodule

// File: tb/tb_debouncing.sv
// -----------------------------------------------------------------------------
// tb_debouncing
//
// Two instances share the stimulus: one with default filtering
// (DEBOUNCE_CYCLES = 1) and one with DEBOUNCE_CYCLES = 4. A reference model
// derives the expected buttonMux of both from the history of sampled row
// values and pushes it into per-instance queues; a monitor pops and compares
// every cycle. Directed scenarios additionally count pulses.
// -----------------------------------------------------------------------------
module tb_debouncing;

    localparam int W    = 4;
    localparam int SYNC = 2;

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] row;
    logic [W-1:0] bm0;
    logic [W-1:0] bm1;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses0  = 0;
    int pulses1  = 0;
    int cyc      = 0;

    debouncing #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row       (row),
        .buttonMux (bm0)
    );

    debouncing #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row       (row),
        .buttonMux (bm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ model
    // A bit's filtered state flips once the synchronised input (row delayed
    // by SYNC edges) has shown the opposite value on the last N edges since
    // reset. A press pulse is a 0->1 flip of that state.
    logic [W-1:0] hist[$];     // row sampled at each edge since reset
    logic [W-1:0] sq[$];       // synchronised value seen by each edge
    logic [W-1:0] stab [2];
    int           nc   [2] = '{1, 4};
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];

    function automatic logic [W-1:0] select_pulses(input logic [W-1:0] r);
        logic [W-1:0] o;
        o = r;
`ifdef DEBOUNCING_ONEHOT_EN
        o = '0;
        for (int b = W - 1; b >= 0; b--) begin
            if (r[b]) o = '0 | (W'(1) << b);
        end
`endif
        return o;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] s_now;
        logic [W-1:0] newst;
        logic [W-1:0] pulse;
        bit           flip;
        if (!rst) begin
            hist.delete();
            sq.delete();
            stab[0] = '0;
            stab[1] = '0;
            exp0_q.push_back('0);
            exp1_q.push_back('0);
        end else begin
            s_now = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : '0;
            sq.push_back(s_now);
            for (int k = 0; k < 2; k++) begin
                newst = stab[k];
                for (int b = 0; b < W; b++) begin
                    flip = (sq.size() >= nc[k]);
                    for (int i = 0; i < nc[k] && flip; i++) begin
                        if (sq[sq.size() - 1 - i][b] == stab[k][b]) flip = 0;
                    end
                    if (flip) newst[b] = ~stab[k][b];
                end
                pulse   = select_pulses(newst & ~stab[k]) & {W{en}};
                stab[k] = newst;
                if (k == 0) exp0_q.push_back(pulse);
                else        exp1_q.push_back(pulse);
            end
            hist.push_back(row);
            if (hist.size() > 16) void'(hist.pop_front());
            if (sq.size() > 16)   void'(sq.pop_front());
        end
    end

    // ---------------------------------------------------------------- monitor
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        cyc++;
        n_checks++;
        if (exp0_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty_d1 cycle %0d: got %b, no expected value queued", cyc, bm0);
        end else begin
            e = exp0_q.pop_front();
            if (bm0 !== e) begin
                n_fail++;
                $display("FAIL sb_d1 cycle %0d: got %b expected %b", cyc, bm0, e);
            end
        end
        n_checks++;
        if (exp1_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty_d4 cycle %0d: got %b, no expected value queued", cyc, bm1);
        end else begin
            e = exp1_q.pop_front();
            if (bm1 !== e) begin
                n_fail++;
                $display("FAIL sb_d4 cycle %0d: got %b expected %b", cyc, bm1, e);
            end
        end
        pulses0 += $countones(bm0);
        pulses1 += $countones(bm1);
    end

    // --------------------------------------------------------------- stimulus
    task automatic drive(input logic [W-1:0] r, input logic e, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            row = r;
            en  = e;
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d pulses expected %0d", name, got, want);
        end else begin
            $display("check %s: %0d pulses", name, got);
        end
    endtask

    int p0;
    int p1;
    int want_all;

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        row = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive(4'b0000, 1'b0, 4);

        // en low: filtering runs but nothing is output
        p0 = pulses0; p1 = pulses1;
        for (int i = 0; i < 5; i++) drive(W'($urandom_range(0, 15)), 1'b0, 1);
        drive(4'b0000, 1'b0, 10);
        check_count("en_low_d1", pulses0 - p0, 0);
        check_count("en_low_d4", pulses1 - p1, 0);

        // single press on bit 0
        drive(4'b0000, 1'b1, 2);
        p0 = pulses0; p1 = pulses1;
        drive(4'b0001, 1'b1, 10);
        check_count("press_b0_d1", pulses0 - p0, 1);
        check_count("press_b0_d4", pulses1 - p1, 1);
        drive(4'b0000, 1'b1, 10);

        // press bit 3, release produces nothing
        p0 = pulses0; p1 = pulses1;
        drive(4'b1000, 1'b1, 10);
        drive(4'b0000, 1'b1, 10);
        check_count("press_release_b3_d1", pulses0 - p0, 1);
        check_count("press_release_b3_d4", pulses1 - p1, 1);

        // bounce on bit 2 then hold
        p0 = pulses0; p1 = pulses1;
        drive(4'b0100, 1'b1, 1);
        drive(4'b0000, 1'b1, 1);
        drive(4'b0100, 1'b1, 1);
        drive(4'b0000, 1'b1, 1);
        drive(4'b0100, 1'b1, 10);
        drive(4'b0000, 1'b1, 10);
        check_count("bounce_b2_d1", pulses0 - p0, 3);
        check_count("bounce_b2_d4", pulses1 - p1, 1);

        // all four rise with en dropped before the pulse
        p0 = pulses0; p1 = pulses1;
        drive(4'b1111, 1'b0, 10);
        drive(4'b0000, 1'b0, 10);
        check_count("all_en_low_d1", pulses0 - p0, 0);
        check_count("all_en_low_d4", pulses1 - p1, 0);

        // all four rise with en high
`ifdef DEBOUNCING_ONEHOT_EN
        want_all = 1;
`else
        want_all = 4;
`endif
        p0 = pulses0; p1 = pulses1;
        drive(4'b1111, 1'b1, 10);
        drive(4'b0000, 1'b1, 10);
        check_count("all_en_high_d1", pulses0 - p0, want_all);
        check_count("all_en_high_d4", pulses1 - p1, want_all);

        // key held through a reset pulses again after release
        p0 = pulses0; p1 = pulses1;
        drive(4'b0010, 1'b1, 10);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(4'b0010, 1'b1, 10);
        drive(4'b0000, 1'b1, 10);
        check_count("reset_held_d1", pulses0 - p0, 2);
        check_count("reset_held_d4", pulses1 - p1, 2);

        // random traffic, checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] r;
            r = row;
            if ($urandom_range(0, 3) == 0) r[$urandom_range(0, W - 1)] = ~r[$urandom_range(0, W - 1)];
            if ($urandom_range(0, 2) == 0) r = r ^ W'(1 << $urandom_range(0, W - 1));
            drive(r, ($urandom_range(0, 7) != 0), 1);
        end
        drive(4'b0000, 1'b1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
